// File: rtl/pipe_stall_ctrl_if.sv
// Hazard/stall handshake bundle between the pipeline datapath and pipe_stall_ctrl.
// master = datapath side (drives hazard info), slave = controller side.
interface pipe_stall_ctrl_if;
    logic [4:0]  D_rs;
    logic [4:0]  D_rt;
    logic        D_UsesRt;
    logic        E_MemRead;
    logic [4:0]  E_REG;
    logic        E_BranchTaken;
    logic        M_MemReq;
    logic        mem_ack;
    logic        W_Halt;
    logic        mem_req;
    logic        F_stall;
    logic        D_stall;
    logic        E_stall;
    logic        M_stall;
    logic        D_flush;
    logic        E_flush;
    logic        W_flush;
    logic        halted;
    logic        mem_timeout;
    logic [15:0] stall_count;

    modport master (
        output D_rs, D_rt, D_UsesRt, E_MemRead, E_REG, E_BranchTaken,
               M_MemReq, mem_ack, W_Halt,
        input  mem_req, F_stall, D_stall, E_stall, M_stall,
               D_flush, E_flush, W_flush, halted, mem_timeout, stall_count
    );

    modport slave (
        input  D_rs, D_rt, D_UsesRt, E_MemRead, E_REG, E_BranchTaken,
               M_MemReq, mem_ack, W_Halt,
        output mem_req, F_stall, D_stall, E_stall, M_stall,
               D_flush, E_flush, W_flush, halted, mem_timeout, stall_count
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller: load-use interlock, branch squash, data-memory wait, halt/timeout freeze.
// Optional stall cycle counter enabled by defining PIPE_STALL_COUNT_EN.
module pipe_stall_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clock,
    input  logic             reset,
    pipe_stall_ctrl_if.slave bus,
    output logic [1:0]       o_dbg_state
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_next_wait_cnt;
    logic       r_mem_timeout;
    logic       w_next_mem_timeout;
    logic       w_memwait;
    logic       w_load_use;

    assign w_memwait = ((r_state == RUN) && bus.M_MemReq && !bus.mem_ack) ||
                       ((r_state == MEM_WAIT) && !bus.mem_ack);

    assign w_load_use = bus.E_MemRead && (bus.E_REG != 5'd0) &&
                        ((bus.E_REG == bus.D_rs) ||
                         (bus.D_UsesRt && (bus.E_REG == bus.D_rt)));

    // Branch and load-use are also honoured in the ack cycle of MEM_WAIT, since the pipeline moves then.
    always_comb begin
        bus.mem_req = bus.M_MemReq && (r_state != HALT);
        bus.F_stall = 1'b0;
        bus.D_stall = 1'b0;
        bus.E_stall = 1'b0;
        bus.M_stall = 1'b0;
        bus.D_flush = 1'b0;
        bus.E_flush = 1'b0;
        bus.W_flush = 1'b0;
        if (reset) begin
            bus.mem_req = 1'b0;
            bus.D_flush = 1'b1;
            bus.E_flush = 1'b1;
            bus.W_flush = 1'b1;
        end else if ((r_state == HALT) || w_memwait) begin
            bus.F_stall = 1'b1;
            bus.D_stall = 1'b1;
            bus.E_stall = 1'b1;
            bus.M_stall = 1'b1;
            bus.W_flush = 1'b1;
        end else if (bus.E_BranchTaken) begin
            bus.D_flush = 1'b1;
            bus.E_flush = 1'b1;
        end else if (w_load_use) begin
            bus.F_stall = 1'b1;
            bus.D_stall = 1'b1;
            bus.E_flush = 1'b1;
        end
    end

    always_comb begin
        w_next_state       = r_state;
        w_next_wait_cnt    = r_wait_cnt;
        w_next_mem_timeout = r_mem_timeout;
        if (bus.W_Halt) begin
            w_next_state = HALT;
        end else begin
            case (r_state)
                RUN: begin
                    if (bus.M_MemReq && !bus.mem_ack) begin
                        w_next_state    = MEM_WAIT;
                        w_next_wait_cnt = 8'd0;
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_ack) begin
                        w_next_state = RUN;
                    end else if (r_wait_cnt == TIMEOUT_LAST) begin
                        w_next_state       = HALT;
                        w_next_mem_timeout = 1'b1;
                    end else begin
                        w_next_wait_cnt = r_wait_cnt + 8'd1;
                    end
                end
                default: w_next_state = HALT;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= RUN;
            r_wait_cnt    <= 8'd0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_wait_cnt    <= w_next_wait_cnt;
            r_mem_timeout <= w_next_mem_timeout;
        end
    end

    assign bus.halted      = (r_state == HALT);
    assign bus.mem_timeout = r_mem_timeout;
    assign o_dbg_state     = r_state;

`ifdef PIPE_STALL_COUNT_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_count <= 16'd0;
        end else if (bus.F_stall && (r_state != HALT) && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign bus.stall_count = r_stall_count;
`else
    assign bus.stall_count = 16'd0;
`endif
endmodule
